// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared encodings for the sequential arithmetic unit
package arith_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/arith_seq.sv
// rtl/arith_seq.sv - multi-cycle unsigned mul, div/rem and isqrt on one shared add/sub datapath
module arith_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             flag
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = WIDTH + 2;

  state_e           state, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt, cnt_d;
  // hi: MUL upper product / DIV partial remainder / SQRT remainder
  // lo: MUL multiplier+low product / DIV dividend+quotient / SQRT radicand, then root
  // opb: MUL multiplicand / DIV divisor / SQRT root under construction
  logic [WIDTH-1:0] hi, hi_d, lo, lo_d, opb, opb_d;
  logic             flag_q, flag_d;

  logic [AW-1:0]    alu_a, alu_b, alu_res;
  logic             alu_sub;
  logic             ge;
  logic             last;
  logic [WIDTH-1:0] div_shift, sqrt_shift;
  op_e              op_in;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_hi    = hi;
  assign out_lo    = lo;
  assign flag      = flag_q;

  assign op_in      = op_e'(op);
  assign last       = (cnt == CW'(1));
  assign ge         = ~alu_res[AW-1];
  // Remainder candidates used when the trial subtraction goes negative.
  assign div_shift  = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign sqrt_shift = {hi[WIDTH-3:0], lo[WIDTH-1 -: 2]};

  // Shared adder/subtractor: operand selection by the captured op.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sub = 1'b0;
    case (op_q)
      OP_MUL: begin
        alu_a = {2'b00, hi};
        alu_b = lo[0] ? {2'b00, opb} : '0;
      end
      OP_DIV: begin
        alu_a   = {1'b0, hi, lo[WIDTH-1]};
        alu_b   = {2'b00, opb};
        alu_sub = 1'b1;
      end
      OP_SQRT: begin
        // Trial (root << 2) | 1 against (rem << 2) | next two radicand bits.
        alu_a   = {hi, lo[WIDTH-1 -: 2]};
        alu_b   = {opb, 2'b01};
        alu_sub = 1'b1;
      end
      default: ;
    endcase
    alu_res = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
  end

  // Next-state logic for IDLE -> RUN/DONE -> IDLE sequencing.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (op_in == OP_RSVD || (op_in == OP_DIV && in_b == '0)) state_d = ST_DONE;
          else                                                     state_d = ST_RUN;
        end
      end
      ST_RUN:  if (last) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: operand capture on accept, one iteration per RUN cycle.
  always_comb begin
    op_d   = op_q;
    cnt_d  = cnt;
    hi_d   = hi;
    lo_d   = lo;
    opb_d  = opb;
    flag_d = flag_q;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          op_d   = op_in;
          flag_d = 1'b0;
          hi_d   = '0;
          lo_d   = in_a;
          opb_d  = in_b;
          cnt_d  = CW'(WIDTH);
          case (op_in)
            OP_MUL: begin
              lo_d  = in_b;
              opb_d = in_a;
            end
            OP_DIV: begin
              if (in_b == '0) begin
                hi_d   = in_a;
                lo_d   = '1;
                flag_d = 1'b1;
                cnt_d  = '0;
              end
            end
            OP_SQRT: begin
              opb_d = '0;
              cnt_d = CW'(WIDTH / 2);
            end
            default: begin
              lo_d   = '0;
              opb_d  = '0;
              flag_d = 1'b1;
              cnt_d  = '0;
            end
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt - CW'(1);
        case (op_q)
          OP_MUL: begin
            hi_d   = alu_res[WIDTH:1];
            lo_d   = {alu_res[0], lo[WIDTH-1:1]};
            flag_d = (alu_res[WIDTH:1] != '0);
          end
          OP_DIV: begin
            hi_d = ge ? alu_res[WIDTH-1:0] : div_shift;
            lo_d = {lo[WIDTH-2:0], ge};
          end
          OP_SQRT: begin
            hi_d  = ge ? alu_res[WIDTH-1:0] : sqrt_shift;
            opb_d = {opb[WIDTH-2:0], ge};
            // On the final step the finished root replaces the drained radicand.
            lo_d  = last ? {opb[WIDTH-2:0], ge} : {lo[WIDTH-3:0], 2'b00};
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset aborts any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= OP_MUL;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opb    <= '0;
      flag_q <= 1'b0;
    end else begin
      state  <= state_d;
      op_q   <= op_d;
      cnt    <= cnt_d;
      hi     <= hi_d;
      lo     <= lo_d;
      opb    <= opb_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: tb/tb_arith_seq.sv
// tb/tb_arith_seq.sv - randomized self-checking bench for arith_seq against a behavioural model
module tb_arith_seq;
  import arith_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_hi;
  logic [W-1:0] out_lo;
  logic         flag;

  int pass_cnt = 0;
  int total    = 0;

  arith_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hi    (out_hi),
    .out_lo    (out_lo),
    .flag      (flag)
  );

  always #5 clk = ~clk;

  // Reference result {flag, hi, lo} from plain arithmetic.
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned p;
    int unsigned r;
    case (o)
      2'd0: begin
        p = a * b;
        return {(p[2*W-1:W] != 0), p[2*W-1:0]};
      end
      2'd1: begin
        if (b == 0) return {1'b1, a, {W{1'b1}}};
        return {1'b0, a % b, a / b};
      end
      2'd2: begin
        r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        return {1'b0, W'(a - r * r), W'(r)};
      end
      default: return {1'b1, {(2*W){1'b0}}};
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [W-1:0] b);
    if (o == 2'd3 || (o == 2'd1 && b == 0)) return 1;
    if (o == 2'd2) return W / 2;
    return W;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op       = o;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if ({in_ready, out_valid, flag, out_hi, out_lo} !== {1'b1, 1'b0, 1'b0, {(2*W){1'b0}}}) begin
      $display("FAIL reset_state: got %b %b %b %h %h want 1 0 0 00 00", in_ready, out_valid, flag, out_hi, out_lo);
    end else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [1:0]   ops [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    logic [W-1:0] as  [6] = '{8'd200, 8'd200, 8'h55, 8'd255, 8'd225, 8'd0};
    logic [W-1:0] bs  [6] = '{8'd200, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [2*W:0] exp [6] = '{{1'b1, 8'h9C, 8'h40}, {1'b0, 8'd4, 8'd28}, {1'b1, 8'h55, 8'hFF},
                              {1'b0, 8'd30, 8'd15}, {1'b0, 8'd0, 8'd15}, {1'b0, 8'd0, 8'd0}};
    int           lats[6] = '{8, 8, 1, 4, 4, 4};
    int           lat;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(lat);
      total++;
      if (lat !== lats[i]) $display("FAIL directed_lat[%0d]: got %0d want %0d", i, lat, lats[i]);
      else pass_cnt++;
      total++;
      if ({flag, out_hi, out_lo} !== exp[i]) $display("FAIL directed_res[%0d]: got %h want %h", i, {flag, out_hi, out_lo}, exp[i]);
      else pass_cnt++;
      consume();
      total++;
      if ({in_ready, out_valid} !== 2'b10) $display("FAIL directed_idle[%0d]: got %b want 10", i, {in_ready, out_valid});
      else pass_cnt++;
    end
  endtask

  task automatic test_random;
    logic [1:0]   o;
    logic [W-1:0] a, b;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      issue(o, a, b);
      wait_done(lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      total++;
      if (lat !== model_lat(o, b)) $display("FAIL rand_lat[%0d] op=%0d: got %0d want %0d", i, o, lat, model_lat(o, b));
      else pass_cnt++;
      total++;
      if ({flag, out_hi, out_lo} !== model(o, a, b))
        $display("FAIL rand_res[%0d] op=%0d a=%0d b=%0d: got %h want %h", i, o, a, b, {flag, out_hi, out_lo}, model(o, a, b));
      else pass_cnt++;
      consume();
      total++;
      if (in_ready !== 1'b1) $display("FAIL rand_ready[%0d]: got %b want 1", i, in_ready);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure;
    logic [2*W:0] exp;
    int           lat;
    exp = model(2'd0, 8'd123, 8'd45);
    issue(2'd0, 8'd123, 8'd45);
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      op       = 2'($urandom_range(0, 3));
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({out_valid, in_ready} !== 2'b10) $display("FAIL bp_hs[%0d]: got %b want 10", i, {out_valid, in_ready});
      else pass_cnt++;
      total++;
      if ({flag, out_hi, out_lo} !== exp) $display("FAIL bp_hold[%0d]: got %h want %h", i, {flag, out_hi, out_lo}, exp);
      else pass_cnt++;
    end
    op        = 2'd2;
    in_a      = 8'd200;
    in_b      = 8'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_release: got %b want 10", {in_ready, out_valid});
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    total++;
    if (lat !== 4) $display("FAIL bp_next_lat: got %0d want 4", lat);
    else pass_cnt++;
    total++;
    if ({flag, out_hi, out_lo} !== model(2'd2, 8'd200, 8'd0))
      $display("FAIL bp_next_res: got %h want %h", {flag, out_hi, out_lo}, model(2'd2, 8'd200, 8'd0));
    else pass_cnt++;
    consume();
  endtask

  task automatic test_back_to_back;
    logic [1:0]   o;
    logic [W-1:0] a, b;
    int           lat;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      o = 2'(i % 3);
      a = W'($urandom);
      b = W'($urandom_range(1, 255));
      issue(o, a, b);
      wait_done(lat);
      total++;
      if (lat !== model_lat(o, b)) $display("FAIL b2b_lat[%0d]: got %0d want %0d", i, lat, model_lat(o, b));
      else pass_cnt++;
      total++;
      if ({flag, out_hi, out_lo} !== model(o, a, b)) $display("FAIL b2b_res[%0d]: got %h want %h", i, {flag, out_hi, out_lo}, model(o, a, b));
      else pass_cnt++;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({in_ready, out_valid} !== 2'b10) $display("FAIL b2b_ready[%0d]: got %b want 10", i, {in_ready, out_valid});
      else pass_cnt++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int lat;
    issue(2'd0, 8'd255, 8'd255);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, flag, out_hi, out_lo} !== {1'b1, 1'b0, 1'b0, {(2*W){1'b0}}})
      $display("FAIL midrun_reset: got %b %b %b %h %h want 1 0 0 00 00", in_ready, out_valid, flag, out_hi, out_lo);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL midrun_idle: got %b want 10", {in_ready, out_valid});
    else pass_cnt++;
    issue(2'd0, 8'd3, 8'd5);
    wait_done(lat);
    total++;
    if (lat !== 8) $display("FAIL midrun_lat: got %0d want 8", lat);
    else pass_cnt++;
    total++;
    if ({flag, out_hi, out_lo} !== {1'b0, 8'd0, 8'd15}) $display("FAIL midrun_res: got %h want 0000f", {flag, out_hi, out_lo});
    else pass_cnt++;
    consume();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 2'd0;
    in_a      = '0;
    in_b      = '0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
